// File: rtl/regfile_sb.sv
// ============================================================================
// Module   : regfile_sb
// Purpose  : Integer register file (NRD comb reads, 1 write) with per-register
//            pending scoreboard; optional write->read forwarding via the
//            REGFILE_SB_BYPASS_EN compile-time macro.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_sb #(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NRD*AW-1:0]         raddr,
  output logic [NRD*XLEN-1:0]       rdata,
  output logic [NRD-1:0]            rbusy,
  input  logic                      we,
  input  logic [AW-1:0]             waddr,
  input  logic [XLEN-1:0]           wdata,
  input  logic                      iss_valid,
  input  logic [AW-1:0]             iss_rd,
  output logic                      iss_ready,
  input  logic                      flush,
  output logic [$clog2(NREG+1)-1:0] pend_cnt
);

  localparam int CW = $clog2(NREG+1);

  // Register 0 has no storage; index range starts at 1.
  logic [XLEN-1:0] regs_q [1:NREG-1];
  logic [XLEN-1:0] regs_d [1:NREG-1];
  logic [NREG-1:1] pend_q, pend_d;

  logic [NREG-1:1] wr_sel, iss_sel;
  logic            wr_hit, iss_pend, iss_fire;

  // Decoding only in-range nonzero addresses makes out-of-range and r0 inert.
  always_comb begin
    wr_sel   = '0;
    iss_sel  = '0;
    iss_pend = 1'b0;
    for (int r = 1; r < NREG; r++) begin
      wr_sel[r]  = we && (waddr == AW'(r));
      iss_sel[r] = (iss_rd == AW'(r));
      if (iss_sel[r]) iss_pend = pend_q[r];
    end
  end

  assign wr_hit    = |wr_sel;
  assign iss_ready = !flush && (!iss_pend || (we && (waddr == iss_rd)));
  assign iss_fire  = iss_valid && iss_ready;

  always_comb begin
    regs_d = regs_q;
    pend_d = pend_q;
    for (int r = 1; r < NREG; r++) begin
      if (wr_sel[r]) begin
        regs_d[r] = wdata;
        pend_d[r] = 1'b0;
      end
      // A new producer issued alongside the old one's writeback keeps pend set.
      if (iss_fire && iss_sel[r]) pend_d[r] = 1'b1;
    end
    if (flush) pend_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) regs_q[r] <= '0;
      pend_q <= '0;
    end else begin
      regs_q <= regs_d;
      pend_q <= pend_d;
    end
  end

  always_comb begin
    pend_cnt = '0;
    for (int r = 1; r < NREG; r++) pend_cnt = pend_cnt + CW'(pend_q[r]);
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] rd;
    logic            rb;

    assign ra = raddr[i*AW +: AW];

    always_comb begin
      rd = '0;
      rb = 1'b0;
      for (int r = 1; r < NREG; r++) begin
        if (ra == AW'(r)) begin
          rd = regs_q[r];
          rb = pend_q[r];
        end
      end
`ifdef REGFILE_SB_BYPASS_EN
      if (wr_hit && (waddr == ra)) begin
        rd = wdata;
        rb = 1'b0;
      end
`endif
    end

    assign rdata[i*XLEN +: XLEN] = rd;
    assign rbusy[i]              = rb;
  end

`ifndef REGFILE_SB_BYPASS_EN
  logic unused_wr_hit;
  assign unused_wr_hit = wr_hit;
`endif

endmodule

`default_nettype wire

// File: tb/tb_regfile_sb.sv
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Directed self-checking bench for regfile_sb (default parameters).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_regfile_sb;

  localparam int XLEN = 32;
  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;

  logic                clk = 1'b0;
  logic                rst_n;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [NRD-1:0]      rbusy;
  logic                we;
  logic [AW-1:0]       waddr;
  logic [XLEN-1:0]     wdata;
  logic                iss_valid;
  logic [AW-1:0]       iss_rd;
  logic                iss_ready;
  logic                flush;
  logic [5:0]          pend_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  regfile_sb #(.XLEN(XLEN), .NREG(NREG), .NRD(NRD)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .raddr    (raddr),
    .rdata    (rdata),
    .rbusy    (rbusy),
    .we       (we),
    .waddr    (waddr),
    .wdata    (wdata),
    .iss_valid(iss_valid),
    .iss_rd   (iss_rd),
    .iss_ready(iss_ready),
    .flush    (flush),
    .pend_cnt (pend_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the edge; checks run 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    we = 1'b0; waddr = '0; wdata = '0;
    iss_valid = 1'b0; iss_rd = '0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    raddr = {a1, a0};
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    set_rd(5'd0, 5'd0);
    cyc(); cyc();
    #1;
    chk("reset_rdata", 64'(rdata), 64'd0);
    chk("reset_rbusy", 64'(rbusy), 64'd0);
    chk("reset_cnt", 64'(pend_cnt), 64'd0);
    chk("reset_ready", 64'(iss_ready), 64'd1);
    rst_n = 1'b1;

    // Register 0: writes discarded, issue accepted without effect
    cyc();
    we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF;
    iss_valid = 1'b1; iss_rd = 5'd0;
    #1 chk("r0_iss_ready", 64'(iss_ready), 64'd1);
    cyc();
    idle();
    set_rd(5'd0, 5'd0);
    #1;
    chk("r0_rdata", 64'(rdata), 64'd0);
    chk("r0_rbusy", 64'(rbusy), 64'd0);
    chk("r0_cnt", 64'(pend_cnt), 64'd0);

    // Scoreboard round trip on r7
    iss_valid = 1'b1; iss_rd = 5'd7;
    #1 chk("r7_iss_ready", 64'(iss_ready), 64'd1);
    cyc();
    set_rd(5'd7, 5'd0);
    #1;
    chk("r7_rbusy", 64'(rbusy[0]), 64'd1);
    chk("r7_cnt", 64'(pend_cnt), 64'd1);
    chk("r7_waw_stall", 64'(iss_ready), 64'd0);
    cyc();
    idle();
    we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678;
    cyc();
    idle();
    #1;
    chk("r7_rdata", 64'(rdata[31:0]), 64'h1234_5678);
    chk("r7_rbusy_clr", 64'(rbusy[0]), 64'd0);
    chk("r7_cnt_clr", 64'(pend_cnt), 64'd0);

    // Same-cycle issue and writeback to r3: set wins
    iss_valid = 1'b1; iss_rd = 5'd3;
    cyc();
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0033;
    #1 chk("r3_iss_ready", 64'(iss_ready), 64'd1);
    cyc();
    idle();
    set_rd(5'd3, 5'd7);
    #1;
    chk("r3_rdata", 64'(rdata[31:0]), 64'h33);
    chk("r3_rbusy", 64'(rbusy[0]), 64'd1);
    chk("r3_cnt", 64'(pend_cnt), 64'd1);
    chk("r7_port1", 64'(rdata[63:32]), 64'h1234_5678);
    we = 1'b1; waddr = 5'd3; wdata = 32'h0000_0044;
    cyc();
    idle();
    #1 chk("r3_cnt_clr", 64'(pend_cnt), 64'd0);

    // Flush with pend on 1, 2, 9 plus write r2 and issue r4
    iss_valid = 1'b1; iss_rd = 5'd1;
    cyc();
    iss_rd = 5'd2;
    cyc();
    iss_rd = 5'd9;
    cyc();
    idle();
    #1 chk("fl_cnt_before", 64'(pend_cnt), 64'd3);
    flush = 1'b1;
    we = 1'b1; waddr = 5'd2; wdata = 32'h0000_00A5;
    iss_valid = 1'b1; iss_rd = 5'd4;
    #1 chk("fl_iss_ready", 64'(iss_ready), 64'd0);
    cyc();
    idle();
    set_rd(5'd2, 5'd4);
    #1;
    chk("fl_cnt_after", 64'(pend_cnt), 64'd0);
    chk("fl_r2_rdata", 64'(rdata[31:0]), 64'hA5);
    chk("fl_rbusy", 64'(rbusy), 64'd0);

    // Forwarding on port 1 for r12 while pending
    iss_valid = 1'b1; iss_rd = 5'd12;
    cyc();
    idle();
    set_rd(5'd7, 5'd12);
    we = 1'b1; waddr = 5'd12; wdata = 32'hCAFE_0001;
    #1;
`ifdef REGFILE_SB_BYPASS_EN
    chk("fwd_rdata1", 64'(rdata[63:32]), 64'hCAFE_0001);
    chk("fwd_rbusy1", 64'(rbusy[1]), 64'd0);
`else
    chk("fwd_rdata1", 64'(rdata[63:32]), 64'd0);
    chk("fwd_rbusy1", 64'(rbusy[1]), 64'd1);
`endif
    chk("fwd_port0", 64'(rdata[31:0]), 64'h1234_5678);
    cyc();
    idle();
    #1;
    chk("fwd_next_rdata1", 64'(rdata[63:32]), 64'hCAFE_0001);
    chk("fwd_next_rbusy1", 64'(rbusy[1]), 64'd0);

    // Asynchronous reset mid-cycle with r5 written and pending
    we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF;
    cyc();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd5;
    cyc();
    idle();
    set_rd(5'd5, 5'd12);
    #1;
    chk("r5_rdata", 64'(rdata[31:0]), 64'hDEAD_BEEF);
    chk("r5_rbusy", 64'(rbusy[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_rdata", 64'(rdata), 64'd0);
    chk("arst_rbusy", 64'(rbusy), 64'd0);
    chk("arst_cnt", 64'(pend_cnt), 64'd0);
    cyc();
    rst_n = 1'b1;
    we = 1'b1; waddr = 5'd5; wdata = 32'h0000_0001;
    cyc();
    idle();
    #1 chk("post_rst_write", 64'(rdata[31:0]), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
